arm_regfile_mp: RTL

Parametrised multi-port successor to the core's register file, for the next datapath generation.
- Configurable read-port count; two write ports: W1 for ALU/load result, W2 for base-writeback/load return.
- R15 held as a dedicated PC register with read offset.
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard for outstanding loads, driving a stall to the control unit.

---
 rtl/arm_regfile_mp.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/arm_regfile_mp.sv
// arm_regfile_mp
// Multi-port register file for the next datapath generation. It has a
// configurable number of combinational read ports and two write ports: W1
// carries ALU/load results and W2 carries base writeback/load return. The
// top address is a dedicated PC register that reads back with an offset.
// A per-register busy scoreboard tracks outstanding loads and raises a
// stall toward the control unit.
module arm_regfile_mp #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int NUM_RD    = 3,
    parameter int PC_OFFSET = 8,
    parameter int RESET_PC  = 0,
    parameter int BYPASS    = 1
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic [NUM_RD-1:0]        RdEn,
    input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
    output logic [NUM_RD*DATA_W-1:0] RdData,
    input  logic                     WE1,
    input  logic [ADDR_W-1:0]        WA1,
    input  logic [DATA_W-1:0]        WD1,
    input  logic                     WE2,
    input  logic [ADDR_W-1:0]        WA2,
    input  logic [DATA_W-1:0]        WD2,
    input  logic [DATA_W-1:0]        PCNext,
    output logic [DATA_W-1:0]        PC,
    input  logic                     LdIssue,
    input  logic [ADDR_W-1:0]        LdAddr,
    output logic [(2**ADDR_W)-1:0]   Busy,
    output logic                     Stall
);

    localparam int                NUM_REGS    = 2 ** ADDR_W;
    localparam int                NUM_GPR     = NUM_REGS - 1;
    localparam logic [ADDR_W-1:0] PC_ADDR     = ADDR_W'(NUM_REGS - 1);
    localparam logic [DATA_W-1:0] PC_OFFSET_V = DATA_W'(PC_OFFSET);
    localparam logic [DATA_W-1:0] RESET_PC_V  = DATA_W'(RESET_PC);
    localparam bit                BYPASS_EN   = (BYPASS != 0);

    // General-purpose storage. The PC address has no entry here because
    // it lives in its own register.
    logic [DATA_W-1:0]   gpr [NUM_GPR];
    logic [DATA_W-1:0]   pcReg;
    logic [NUM_REGS-1:0] busyReg;
    logic [DATA_W-1:0]   pcRead;
    logic                w1HitsPc;
    logic                w2HitsPc;
    logic                bypassLive;
    logic [NUM_RD-1:0]   portStall;

    // The PC reads back with the pipeline offset and wraps at DATA_W bits.
    assign pcRead = pcReg + PC_OFFSET_V;

    assign w1HitsPc = WE1 && (WA1 == PC_ADDR);
    assign w2HitsPc = WE2 && (WA2 == PC_ADDR);

    // Bypassing is suppressed while reset is held. This makes reads show
    // the zeroed storage even if a write strobe happens to be high.
    assign bypassLive = BYPASS_EN && RSTn;

    // Write the general registers. W1 has priority when both ports target
    // the same register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int r = 0; r < NUM_GPR; r++) begin
                gpr[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_GPR; r++) begin
                if (WE1 && (WA1 == ADDR_W'(r))) begin
                    gpr[r] <= WD1;
                end else if (WE2 && (WA2 == ADDR_W'(r))) begin
                    gpr[r] <= WD2;
                end
            end
        end
    end

    // An explicit write loads the PC exactly, and W1 wins over W2.
    // Otherwise the PC follows the sequential next PC on every cycle.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pcReg <= RESET_PC_V;
        end else if (w1HitsPc) begin
            pcReg <= WD1;
        end else if (w2HitsPc) begin
            pcReg <= WD2;
        end else begin
            pcReg <= PCNext;
        end
    end

    // Load scoreboard. A load issue sets the busy bit and a W2 return
    // clears it. Set wins when both hit together, so a back-to-back load
    // to the same register keeps the bit busy. W1 never clears a bit, and
    // the PC address is never marked busy.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            busyReg <= '0;
        end else begin
            for (int r = 0; r < NUM_GPR; r++) begin
                if (LdIssue && (LdAddr == ADDR_W'(r))) begin
                    busyReg[r] <= 1'b1;
                end else if (WE2 && (WA2 == ADDR_W'(r))) begin
                    busyReg[r] <= 1'b0;
                end
            end
            busyReg[NUM_REGS-1] <= 1'b0;
        end
    end

    // Each read port gets its own data mux and its own stall term.
    for (genvar i = 0; i < NUM_RD; i++) begin : gRead
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              returning;

        assign addr = RdAddr[i*ADDR_W +: ADDR_W];

        // Select the data for this port. The PC address always returns the
        // offset PC. Other addresses take the W1 bypass first, then the W2
        // bypass, and otherwise the stored value.
        always_comb begin
            data = '0;
            if (addr == PC_ADDR) begin
                data = pcRead;
            end else if (bypassLive && WE1 && (WA1 == addr)) begin
                data = WD1;
            end else if (bypassLive && WE2 && (WA2 == addr)) begin
                data = WD2;
            end else begin
                data = gpr[addr];
            end
        end

        // A load returning this cycle lifts the stall only when its data
        // can be forwarded straight to the reader.
        assign returning    = BYPASS_EN && WE2 && (WA2 == addr);
        assign portStall[i] = RdEn[i] && busyReg[addr] && !returning;

        assign RdData[i*DATA_W +: DATA_W] = data;
    end

    assign PC    = pcReg;
    assign Busy  = busyReg;
    assign Stall = |portStall;

endmodule
